// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types, PID codes and CRC16 constants for the USB receive path
package usb_rx_pkg;
    typedef enum logic [2:0] {PK_NONE, PK_ACK, PK_NAK, PK_STALL, PK_DATA0, PK_DATA1} pkt_kind_t;
    typedef enum logic [2:0] {ERR_OK, ERR_TIMEOUT, ERR_PID, ERR_CRC, ERR_LEN} rx_err_t;
    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_PID, S_DATA, S_DONE} rx_state_t;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // PK_NONE for a malformed check nibble or an unsupported PID
    function automatic pkt_kind_t pid_kind(input logic [7:0] pid);
        if (pid[7:4] != ~pid[3:0]) return PK_NONE;
        case (pid[3:0])
            PID_ACK:   return PK_ACK;
            PID_NAK:   return PK_NAK;
            PID_STALL: return PK_STALL;
            PID_DATA0: return PK_DATA0;
            PID_DATA1: return PK_DATA1;
            default:   return PK_NONE;
        endcase
    endfunction
endpackage

// File: rtl/usb_crc16_check.sv
// usb_crc16_check: serial USB CRC16 with clear and bit-enable.
// residual_ok looks ahead so a bit enabled this cycle is already included.
module usb_crc16_check
    import usb_rx_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic bit_en,
    input  logic bit_in,
    output logic residual_ok
);
    logic [15:0] crc, crc_n;

    always_comb begin
        crc_n = clear ? CRC16_INIT
              : bit_en ? {crc[14:0], 1'b0} ^ ((bit_in ^ crc[15]) ? CRC16_POLY : 16'h0000)
              : crc;
        residual_ok = crc_n == CRC16_RESIDUAL;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) crc <= CRC16_INIT;
        else crc <= crc_n;
endmodule

// File: rtl/usb_packet_rx.sv
// usb_packet_rx: host-side USB packet receiver with PID decode, payload
// deserialisation, CRC16 check and response timeout.
module usb_packet_rx
    import usb_rx_pkg::*;
#(
    parameter int MAX_BYTES      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           in_bit,
    input  logic                           in_valid,
    input  logic                           in_eop,
    output logic                           done,
    output logic [2:0]                     kind,
    output logic [2:0]                     err,
    output logic [8*MAX_BYTES-1:0]         data_out,
    output logic [$clog2(MAX_BYTES+1)-1:0] byte_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int NW = $clog2(MAX_BYTES + 3);
    localparam int BW = $clog2(MAX_BYTES + 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [NW-1:0] NB_MAX = NW'(MAX_BYTES + 2);

    rx_state_t state, state_n;
    pkt_kind_t pkind, pkind_n;
    rx_err_t   perr, perr_n;
    logic [TW-1:0] tcnt;
    logic [7:0]    sh, sh_n;
    logic [2:0]    bit_cnt, bc_n;
    logic [NW-1:0] nbytes, nb_n;
    logic [15:0]   pend;
    logic [BW-1:0] bcnt_n;
    logic pid_full, ovf, ovf_n, take, byte_done, is_data, arm, crc_ok;

    assign arm       = state == S_IDLE && start && !abort;
    assign take      = in_valid && (state == S_ARMED || (state == S_PID && !pid_full)
                                    || (state == S_DATA && nbytes != NB_MAX));
    assign byte_done = take && bit_cnt == 3'd7;
    assign sh_n      = {in_bit, sh[7:1]};
    assign bc_n      = bit_cnt + 3'(take);
    assign nb_n      = nbytes + NW'(byte_done && state == S_DATA);
    assign ovf_n     = ovf || (state == S_DATA && in_valid && nbytes == NB_MAX);
    assign is_data   = pid_kind(sh_n) inside {PK_DATA0, PK_DATA1};

    usb_crc16_check u_crc (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (state == S_IDLE && start),
        .bit_en      (take && state == S_DATA),
        .bit_in      (in_bit),
        .residual_ok (crc_ok)
    );

    always_comb begin
        state_n = state;
        pkind_n = pkind;
        perr_n  = perr;
        bcnt_n  = byte_count;
        case (state)
            S_IDLE: state_n = start ? S_ARMED : S_IDLE;
            S_ARMED: begin
                if (in_valid) state_n = S_PID;
                else if (tcnt == T_MAX) begin
                    state_n = S_DONE;
                    pkind_n = PK_NONE;
                    perr_n  = ERR_TIMEOUT;
                end
            end
            S_PID: begin
                if (byte_done) begin
                    pkind_n = pid_kind(sh_n);
                    perr_n  = pkind_n == PK_NONE ? ERR_PID : ERR_OK;
                    state_n = is_data ? S_DATA : S_PID;
                end else if (pid_full && in_valid && perr == ERR_OK) perr_n = ERR_LEN;
                // a truncated PID is reported as unrecognised
                if (in_eop) begin
                    state_n = S_DONE;
                    if (!pid_full && !byte_done) begin
                        pkind_n = PK_NONE;
                        perr_n  = ERR_PID;
                    end else if (byte_done && is_data) perr_n = ERR_LEN;
                end
            end
            S_DATA: begin
                if (in_eop) begin
                    state_n = S_DONE;
                    if (ovf_n || bc_n != 3'd0 || nb_n < NW'(2)) perr_n = ERR_LEN;
                    else begin
                        perr_n = crc_ok ? ERR_OK : ERR_CRC;
                        bcnt_n = BW'(nb_n - NW'(2));
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort) state_n = S_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= S_IDLE;
        else state <= state_n;

    // the newest two bytes are held back in pend: they may turn out to be the CRC field
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            done       <= 1'b0;
            kind       <= PK_NONE;
            err        <= ERR_OK;
            data_out   <= '0;
            byte_count <= '0;
            pkind      <= PK_NONE;
            perr       <= ERR_OK;
            tcnt       <= '0;
            sh         <= '0;
            bit_cnt    <= '0;
            nbytes     <= '0;
            pend       <= '0;
            pid_full   <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= state_n == S_DONE;
            if (arm) begin
                data_out   <= '0;
                byte_count <= '0;
                pkind      <= PK_NONE;
                perr       <= ERR_OK;
                tcnt       <= '0;
                sh         <= '0;
                bit_cnt    <= '0;
                nbytes     <= '0;
                pend       <= '0;
                pid_full   <= 1'b0;
                ovf        <= 1'b0;
            end else begin
                pkind <= pkind_n;
                perr  <= perr_n;
                ovf   <= ovf_n;
                if (state == S_ARMED) tcnt <= tcnt + TW'(1);
                if (take) begin
                    sh      <= sh_n;
                    bit_cnt <= bc_n;
                end
                if (state == S_PID && byte_done) pid_full <= 1'b1;
                if (state == S_DATA && byte_done) begin
                    nbytes <= nb_n;
                    pend   <= {sh_n, pend[15:8]};
                    for (int k = 0; k < MAX_BYTES; k++)
                        if (nbytes >= NW'(2) && nbytes - NW'(2) == NW'(k)) data_out[8*k +: 8] <= pend[7:0];
                end
                if (state_n == S_DONE) begin
                    kind       <= pkind_n;
                    err        <= perr_n;
                    byte_count <= bcnt_n;
                end
            end
        end
endmodule

// File: tb/tb_usb_packet_rx.sv
// tb_usb_packet_rx: directed self-checking bench for usb_packet_rx
// (MAX_BYTES=4, TIMEOUT_CYCLES=20); inputs driven and outputs sampled on the falling edge.
module tb_usb_packet_rx;
    localparam int MB = 4;
    localparam int TO = 20;

    logic clock = 1'b0;
    logic reset_n, start, abort, in_bit, in_valid, in_eop;
    logic done;
    logic [2:0] kind, err;
    logic [8*MB-1:0] data_out;
    logic [$clog2(MB+1)-1:0] byte_count;

    int checks = 0;
    int errors = 0;

    usb_packet_rx #(.MAX_BYTES(MB), .TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_eop     (in_eop),
        .done       (done),
        .kind       (kind),
        .err        (err),
        .data_out   (data_out),
        .byte_count (byte_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
    endtask

    task automatic pulse_eop();
        in_eop = 1'b1;
        @(negedge clock);
        in_eop = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic e, input int gap);
        repeat (gap) @(negedge clock);
        in_bit   = b;
        in_valid = 1'b1;
        in_eop   = e;
        @(negedge clock);
        in_valid = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic eop_last, input logic gaps);
        for (int i = 0; i < 8; i++)
            send_bit(b[i], eop_last && i == 7, gaps ? int'($urandom_range(2)) : 0);
    endtask

    task automatic check_result(input string tag, input logic [2:0] k, input logic [2:0] e, input int bc);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".kind"}, 32'(kind), 32'(k));
        check({tag, ".err"}, 32'(err), 32'(e));
        check({tag, ".bytes"}, 32'(byte_count), 32'(bc));
        @(negedge clock);
        check({tag, ".done_off"}, 32'(done), 32'd0);
    endtask

    function automatic logic [15:0] crc16(input logic [31:0] d, input int nbits);
        logic [15:0] r = 16'hFFFF;
        for (int i = 0; i < nbits; i++)
            r = {r[14:0], 1'b0} ^ ((d[i] ^ r[15]) ? 16'h8005 : 16'h0000);
        return r;
    endfunction

    initial begin
        logic [15:0] c;
        logic [7:0] c0, c1;
        int n, nd;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        in_bit = 1'b0; in_valid = 1'b0; in_eop = 1'b0;
        repeat (3) @(negedge clock);
        check("rst.done", 32'(done), 32'd0);
        check("rst.kind", 32'(kind), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.data", data_out, 32'd0);
        check("rst.bytes", 32'(byte_count), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        pulse_start(); send_byte(8'hD2, 1'b0, 1'b0); pulse_eop();
        check_result("ack", 3'd1, 3'd0, 0);

        pulse_start(); send_byte(8'hC3, 1'b0, 1'b0); send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0); pulse_eop();
        check_result("data0_empty", 3'd4, 3'd0, 0);

        pulse_start(); send_byte(8'hC3, 1'b0, 1'b0); send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0); pulse_eop();
        check_result("data0_badcrc", 3'd4, 3'd3, 0);

        c = ~crc16(32'h00030201, 24);
        for (int j = 0; j < 8; j++) begin
            c0[j] = c[15-j];
            c1[j] = c[7-j];
        end
        pulse_start(); send_byte(8'h4B, 1'b0, 1'b1);
        send_byte(8'h01, 1'b0, 1'b1); send_byte(8'h02, 1'b0, 1'b1); send_byte(8'h03, 1'b0, 1'b1);
        send_byte(c0, 1'b0, 1'b1); send_byte(c1, 1'b1, 1'b1);
        check("data1.payload", data_out, 32'h00030201);
        check_result("data1", 3'd5, 3'd0, 3);

        pulse_start(); send_byte(8'h12, 1'b0, 1'b0); pulse_eop();
        check_result("badpid", 3'd0, 3'd2, 0);

        pulse_start(); send_byte(8'hD2, 1'b0, 1'b0); send_bit(1'b1, 1'b0, 0); pulse_eop();
        check_result("ack_9bit", 3'd1, 3'd4, 0);

        pulse_start(); send_byte(8'hC3, 1'b0, 1'b0); send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0); send_bit(1'b0, 1'b0, 0); pulse_eop();
        check_result("partial_byte", 3'd4, 3'd4, 0);

        pulse_start(); send_byte(8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < MB + 3; i++) send_byte(8'h00, 1'b0, 1'b0);
        pulse_eop();
        check_result("overflow", 3'd4, 3'd4, 0);

        pulse_start();
        n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("timeout.latency", 32'(n), 32'(TO + 1));
        check_result("timeout", 3'd0, 3'd1, 0);

        pulse_start(); send_byte(8'hC3, 1'b0, 1'b0); send_byte(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 0);
        pulse_abort();
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            in_eop = (i == 5);
            @(negedge clock);
            nd += int'(done);
        end
        in_eop = 1'b0;
        check("abort.no_done", 32'(nd), 32'd0);
        check("abort.kind", 32'(kind), 32'd0);
        check("abort.err", 32'(err), 32'd1);

        pulse_start(); send_byte(8'hC3, 1'b0, 1'b0); send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0); send_byte(8'h03, 1'b0, 1'b0);
        check("midrst.pre_data", data_out, 32'h00000001);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.kind", 32'(kind), 32'd0);
        check("midrst.err", 32'(err), 32'd0);
        check("midrst.data", data_out, 32'd0);
        check("midrst.bytes", 32'(byte_count), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        pulse_start(); send_byte(8'h5A, 1'b0, 1'b0); pulse_eop();
        check_result("nak", 3'd2, 3'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_packet_rx.md
# usb_packet_rx

Parametrised USB host-side packet receiver. It sits after the DP/DM decode, NRZI decode and bit-unstuffing chain and consumes the unstuffed serial bit stream. It decodes and validates the PID, then classifies the packet as ACK, NAK, STALL, DATA0 or DATA1. For data packets it deserialises a variable-length payload of up to MAX_BYTES bytes, checks CRC16, and reports one result per armed receive to the read/write transaction FSM, including a response timeout.

## Interface
- MAX_BYTES, 8, maximum payload bytes accepted in a DATA packet (≥1)
- TIMEOUT_CYCLES, 255, clocks allowed between `start` and the first bit before timeout (≥1)

- clock  in  1  system clock
- reset_n  in  1  reset; reset reset_n, asynchronous, active-low; clock clock
- start  in  1  one-cycle pulse: arm the receiver for one packet
- abort  in  1  one-cycle pulse: drop the current packet and return to IDLE, with no `done`
- in_bit  in  1  unstuffed bit, sent LSB-first
- in_valid  in  1  `in_bit` is valid this cycle
- in_eop  in  1  end-of-packet strobe
- done  out  1  one-cycle pulse: the result fields are updated
- kind  out  3  pkt_kind_t: NONE, ACK, NAK, STALL, DATA0, DATA1
- err  out  3  rx_err_t: OK, TIMEOUT, PID_ERR, CRC_ERR, LEN_ERR
- data_out  out  8*MAX_BYTES  payload; byte k is at [8k+7:8k]; unreceived bytes are 0
- byte_count  out  $clog2(MAX_BYTES+1)  number of payload bytes, excluding the CRC

## Operation
- States: IDLE, ARMED, PID, DATA, DONE.
- IDLE: `in_valid` and `in_eop` are ignored. `start` moves to ARMED, clears the timeout counter and the shift state, and zeroes data_out and byte_count.
- ARMED: the counter increments every cycle.
  - `in_valid` moves to PID; that bit is PID bit 0.
  - When the counter reaches TIMEOUT_CYCLES: kind=NONE, err=TIMEOUT, go to DONE.
- PID: collect 8 bits. The PID is valid only when pid[7:4] == ~pid[3:0] and pid[3:0] ∈ {ACK 0010, NAK 1010, STALL 1110, DATA0 0011, DATA1 1011}.
  - A valid handshake PID requires `in_eop` immediately after bit 7. A 9th bit gives LEN_ERR.
  - A valid data PID moves to DATA.
  - Any other PID: err=PID_ERR. Remaining bits are ignored until `in_eop`, then go to DONE.
- DATA: every bit feeds the CRC checker and a byte shifter. Completed bytes go to a byte buffer, with the last 2 bytes treated as the CRC field.
  - On `in_eop`:
    - If the bit count is not a multiple of 8, or fewer than 2 bytes arrived: LEN_ERR.
    - Otherwise byte_count = bytes − 2, and CRC is checked: residual ≠ 16'h800D gives CRC_ERR, else OK.
  - More than MAX_BYTES+2 bytes: LEN_ERR is latched, further bits are discarded, and the block waits for `in_eop`.
- CRC16: register init 16'hFFFF. Per bit: fb = b ^ r[15]; r = {r[14:0],1'b0} ^ (fb ? 16'h8005 : 0).
- DONE: pulse `done` for exactly one cycle, then go to IDLE.
- Result fields:
  - kind reflects the decoded PID on every error except PID_ERR and TIMEOUT, where it is NONE.
  - All result fields hold until the next `start`.
- `abort` in any state goes to IDLE on the next edge with result fields unchanged. `abort` beats `start` when both are asserted.
- `start` outside IDLE is ignored.
- `in_valid` and `in_eop` in the same cycle: the bit is consumed first, then EOP is evaluated including that bit.

## Timing
- Reset: state=IDLE; done=0, kind=NONE, err=OK, data_out=0, byte_count=0. Asserting reset mid-packet discards the packet and emits no `done`.
- `done` is asserted in the cycle after the edge that samples `in_eop` (or the timeout). Latency is 1 clock.
- Timeout: `done` asserts TIMEOUT_CYCLES+1 clocks after the `start` edge, provided no `in_valid` arrived.
- All outputs are registered. The block accepts one bit per clock at most; gaps in `in_valid` are allowed.

## Structure
- Package usb_rx_pkg: pkt_kind_t, rx_err_t, the PID constants, CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF, CRC16_RESIDUAL=16'h800D.
- Sub-module usb_crc16_check: a serial CRC16 with clear, bit-enable and `residual_ok` output. It is reusable by the transmit path.

## Test plan
- `start`, then 0xD2 LSB-first, then `in_eop` → `done` 1 cycle after EOP, kind=ACK, err=OK, byte_count=0.
- `start`, bytes 0xC3 0x00 0x00, then EOP → kind=DATA0, err=OK, byte_count=0. Same with last byte 0x01 → err=CRC_ERR.
- `start`, DATA1 0x4B + payload 0x01 0x02 0x03 + bench-model CRC, with random `in_valid` gaps → err=OK, byte_count=3, data_out[23:0]=24'h030201.
- `start`, byte 0x12 then EOP → kind=NONE, err=PID_ERR. Separately, DATA0 with MAX_BYTES+3 bytes → LEN_ERR.
- `start`, idle → `done` with err=TIMEOUT exactly TIMEOUT_CYCLES+1 clocks later. Then `abort` mid-DATA → no `done`, state=IDLE.
- Reset asserted mid-DATA → all outputs return to their reset values. The next `start` plus a NAK (0x5A) → kind=NAK, err=OK.
